// File: rtl/sd_frame_pkg.sv
// Shared constants and FSM state encoding for the SD frame packer.
package sd_frame_pkg;

  localparam int FRAME_W        = 640;
  localparam int FRAME_H        = 480;
  localparam int FRAME_BYTES    = FRAME_W * FRAME_H;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FLUSH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sd_frame_packer_if.sv
// Word write port from the packer to the frame-buffer BRAM arbiter.
interface sd_frame_packer_if #(
  parameter int ADDR_W = 17
) ();
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_addr, output out_data, output out_valid, input out_ready);
  modport slave  (input out_addr, input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sd_word_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sd_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 49
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/sd_frame_packer.sv
// Packs the reader's byte stream little-endian into addressed 32-bit words for the BRAM arbiter.
// state   | meaning
// S_FILL  | accepting bytes
// S_FLUSH | pushing the zero-padded partial word
// S_DRAIN | waiting for the word FIFO to empty
// S_DONE  | frame written, idle until restart
module sd_frame_packer
  import sd_frame_pkg::*;
#(
  parameter int FRAME_BYTES = sd_frame_pkg::FRAME_BYTES,
  parameter int ADDR_W      = 17,
  parameter int BASE_ADDR   = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_we,
  input  logic [7:0]           in_data,
  input  logic                 in_frame_done,
  input  logic                 restart,
  sd_frame_packer_if.master    wr,
  output logic                 frame_ready,
  output logic [18:0]          byte_count,
  output logic                 overflow,
  output logic                 size_error
);
  localparam int                LANE_W    = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);
  localparam logic [18:0]       FRAME_LEN = 19'(FRAME_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_RST  = ADDR_W'(BASE_ADDR);

  state_e              state_q, state_d;
  logic [LANE_W-1:0]   lane_q, lane_d, lane_next;
  logic [31:0]         asm_q, asm_d;
  logic                pend_q, pend_d;
  logic [18:0]         count_q, count_d, count_next;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ovf_q, ovf_d, serr_q, serr_d, fr_q, fr_d;
  logic                accept, push, pop, frame_end, fifo_full, fifo_empty;
  logic [ADDR_W+31:0]  fifo_dout;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = S_FILL;
    end else begin
      case (state_q)
        S_FILL:  if (in_frame_done) state_d = (lane_next != '0) ? S_FLUSH : S_DRAIN;
        S_FLUSH: state_d = S_DRAIN;
        S_DRAIN: if (fifo_empty && !pend_q) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    accept     = (state_q == S_FILL) && in_we && !restart && (count_q != FRAME_LEN);
    lane_next  = lane_q + LANE_W'(accept);
    count_next = count_q + 19'(accept);
    frame_end  = (state_q == S_FILL) && in_frame_done && !restart;
    push       = (pend_q || (state_q == S_FLUSH)) && !restart;
    pop        = !fifo_empty && wr.out_ready;
  end

  // A push clears the lanes first so a byte arriving in the same cycle lands in a fresh word.
  always_comb begin
    lane_d  = lane_q;
    asm_d   = asm_q;
    pend_d  = 1'b0;
    count_d = count_q;
    addr_d  = addr_q;
    ovf_d   = ovf_q;
    serr_d  = serr_q;
    fr_d    = 1'b0;
    if (restart) begin
      lane_d  = '0;
      asm_d   = '0;
      count_d = '0;
      addr_d  = ADDR_RST;
      ovf_d   = 1'b0;
      serr_d  = 1'b0;
    end else begin
      if (push) begin
        asm_d  = '0;
        addr_d = addr_q + ADDR_W'(1);
        if (fifo_full && !pop) ovf_d = 1'b1;
      end
      if (state_q == S_FLUSH) lane_d = '0;
      if (accept) begin
        asm_d[{lane_q, 3'b000} +: 8] = in_data;
        lane_d  = lane_next;
        count_d = count_next;
        pend_d  = (lane_q == LAST_LANE);
      end
      if ((state_q == S_FILL) && in_we && (count_q == FRAME_LEN)) serr_d = 1'b1;
      if (frame_end && (count_next != FRAME_LEN)) serr_d = 1'b1;
      if ((state_q == S_DRAIN) && (state_d == S_DONE)) fr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q  <= '0;
      asm_q   <= '0;
      pend_q  <= 1'b0;
      count_q <= '0;
      addr_q  <= ADDR_RST;
      ovf_q   <= 1'b0;
      serr_q  <= 1'b0;
      fr_q    <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
      serr_q  <= serr_d;
      fr_q    <= fr_d;
    end
  end

  sd_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + 32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (restart),
    .push  (push),
    .pop   (pop),
    .din   ({addr_q, asm_q}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wr.out_valid = !fifo_empty;
  assign wr.out_data  = fifo_empty ? 32'd0 : fifo_dout[31:0];
  assign wr.out_addr  = fifo_empty ? ADDR_RST : fifo_dout[ADDR_W+31:32];
  assign frame_ready  = fr_q;
  assign byte_count   = count_q;
  assign overflow     = ovf_q;
  assign size_error   = serr_q;
endmodule
